// File: rtl/flex_sr_pkg.sv
// Shared types and helpers for the flex_dr_sr JTAG data register family.
package flex_sr_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    LOADED   = 2'b01,
    SHIFTING = 2'b10,
    FULL     = 2'b11
  } sr_state_t;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/flex_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky flag that is set
// when an increment is requested while already at MAX.
module flex_sat_counter
  import flex_sr_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W   = count_width(MAX)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max,
  output logic         rollover
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign at_max = (count == MAX_V);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count    <= '0;
      rollover <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      rollover <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        rollover <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/flex_dr_sr.sv
// Capture/shift/update data register for JTAG DRs with shadow update register,
// saturating shift counter and state tracker. Optional: FLEX_DR_SR_PARITY_EN.
module flex_dr_sr
  import flex_sr_pkg::*;
#(
  parameter int                  NUM_BITS    = 8,
  parameter int                  SHIFT_MSB   = 1,
  parameter logic [NUM_BITS-1:0] UPD_RST_VAL = '0
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               capture_en,
  input  logic                               shift_en,
  input  logic                               update_en,
  input  logic                               serial_in,
  input  logic [NUM_BITS-1:0]                parallel_in,
  output logic                               serial_out,
  output logic [NUM_BITS-1:0]                shift_reg,
  output logic [NUM_BITS-1:0]                update_out,
  output logic [count_width(NUM_BITS)-1:0]   shift_count,
  output logic                               shift_full,
  output logic                               overflow,
  output sr_state_t                          sr_state
`ifdef FLEX_DR_SR_PARITY_EN
  ,
  output logic                               update_parity
`endif
);

  localparam int            CW   = count_width(NUM_BITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  logic                do_cap;
  logic                do_shift;
  logic                do_upd;
  logic                cnt_at_max;
  logic [NUM_BITS-1:0] shifted;
  sr_state_t           state_next;

  // Capture wins over shift, shift wins over update.
  assign do_cap   = capture_en;
  assign do_shift = shift_en & ~capture_en;
  assign do_upd   = update_en & ~capture_en & ~shift_en;

  always_comb begin
    shifted = shift_reg;
    if (SHIFT_MSB != 0) begin
      shifted = {shift_reg[NUM_BITS-2:0], serial_in};
    end else begin
      shifted = {serial_in, shift_reg[NUM_BITS-1:1]};
    end
  end

  assign serial_out = (SHIFT_MSB != 0) ? shift_reg[NUM_BITS-1] : shift_reg[0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_reg <= '1;
    end else if (do_cap) begin
      shift_reg <= parallel_in;
    end else if (do_shift) begin
      shift_reg <= shifted;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      update_out <= UPD_RST_VAL;
    end else if (do_upd) begin
      update_out <= shift_reg;
    end
  end

`ifdef FLEX_DR_SR_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      update_parity <= 1'b0;
    end else if (do_upd) begin
      update_parity <= ^shift_reg;
    end
  end
`endif

  flex_sat_counter #(
    .MAX (NUM_BITS),
    .W   (CW)
  ) u_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (do_cap),
    .inc      (do_shift),
    .count    (shift_count),
    .at_max   (cnt_at_max),
    .rollover (overflow)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_state <= EMPTY;
    end else begin
      sr_state <= state_next;
    end
  end

  // A shift from LAST (or already saturated) lands in FULL.
  always_comb begin
    state_next = sr_state;
    if (do_cap) begin
      state_next = LOADED;
    end else if (do_shift) begin
      if (cnt_at_max || (shift_count == LAST)) begin
        state_next = FULL;
      end else begin
        state_next = SHIFTING;
      end
    end
  end

  assign shift_full = (sr_state == FULL);

endmodule

// File: tb/tb_flex_dr_sr.sv
// Directed self-checking bench for flex_dr_sr: MSB-shift instance plus an
// LSB-shift instance driven by the same stimulus.
module tb_flex_dr_sr;
  import flex_sr_pkg::*;

  logic       clk;
  logic       n_rst;
  logic       capture_en;
  logic       shift_en;
  logic       update_en;
  logic       serial_in;
  logic [7:0] parallel_in;

  logic       so_m, so_l;
  logic [7:0] sr_m, sr_l, up_m, up_l;
  logic [3:0] cnt_m, cnt_l;
  logic       full_m, full_l, ovf_m, ovf_l;
  sr_state_t  st_m, st_l;
`ifdef FLEX_DR_SR_PARITY_EN
  logic       par_m, par_l;
`endif

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [0:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  flex_dr_sr #(.NUM_BITS(8), .SHIFT_MSB(1)) dut_m (
    .clk(clk), .n_rst(n_rst), .capture_en(capture_en), .shift_en(shift_en),
    .update_en(update_en), .serial_in(serial_in), .parallel_in(parallel_in),
    .serial_out(so_m), .shift_reg(sr_m), .update_out(up_m), .shift_count(cnt_m),
    .shift_full(full_m), .overflow(ovf_m), .sr_state(st_m)
`ifdef FLEX_DR_SR_PARITY_EN
    , .update_parity(par_m)
`endif
  );

  flex_dr_sr #(.NUM_BITS(8), .SHIFT_MSB(0)) dut_l (
    .clk(clk), .n_rst(n_rst), .capture_en(capture_en), .shift_en(shift_en),
    .update_en(update_en), .serial_in(serial_in), .parallel_in(parallel_in),
    .serial_out(so_l), .shift_reg(sr_l), .update_out(up_l), .shift_count(cnt_l),
    .shift_full(full_l), .overflow(ovf_l), .sr_state(st_l)
`ifdef FLEX_DR_SR_PARITY_EN
    , .update_parity(par_l)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cap, input logic sh, input logic upd,
                       input logic si, input logic [7:0] pin);
    capture_en  = cap;
    shift_en    = sh;
    update_en   = upd;
    serial_in   = si;
    parallel_in = pin;
    tick();
    capture_en = 1'b0;
    shift_en   = 1'b0;
    update_en  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sr"},    sr_m,   8'hFF);
    check({tag, "_up"},    up_m,   8'h00);
    check({tag, "_cnt"},   cnt_m,  4'd0);
    check({tag, "_ovf"},   ovf_m,  1'b0);
    check({tag, "_full"},  full_m, 1'b0);
    check({tag, "_st"},    st_m,   EMPTY);
    check({tag, "_so"},    so_m,   1'b1);
    check({tag, "_sr_l"},  sr_l,   8'hFF);
  endtask

  initial begin
    logic [7:0] pat;
    n_rst = 1'b0;
    capture_en = 1'b0; shift_en = 1'b0; update_en = 1'b0;
    serial_in = 1'b0; parallel_in = 8'h00;
    #12;
    check_reset_vals("rst");
    n_rst = 1'b1;
    tick();

    // shift from EMPTY starts from all ones
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("empty_shift_sr",  sr_m,  8'hFE);
    check("empty_shift_srl", sr_l,  8'h7F);
    check("empty_shift_cnt", cnt_m, 4'd1);
    check("empty_shift_st",  st_m,  SHIFTING);

    // capture A5 and shift it out MSB first
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    check("cap_a5_st",  st_m,  LOADED);
    check("cap_a5_cnt", cnt_m, 4'd0);
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("so_a5_%0d", i), so_m, exp_q.pop_front());
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    check("a5_sr",   sr_m,   8'h00);
    check("a5_cnt",  cnt_m,  4'd8);
    check("a5_full", full_m, 1'b1);
    check("a5_st",   st_m,   FULL);
    check("a5_ovf",  ovf_m,  1'b0);

    // shift while full
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    check("ovf_sr",  sr_m,  8'h01);
    check("ovf_ovf", ovf_m, 1'b1);
    check("ovf_cnt", cnt_m, 4'd8);
    check("ovf_st",  st_m,  FULL);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    check("cap_3c_ovf",  ovf_m,  1'b0);
    check("cap_3c_cnt",  cnt_m,  4'd0);
    check("cap_3c_st",   st_m,   LOADED);
    check("cap_3c_full", full_m, 1'b0);

    // LSB-direction instance: capture 81, three shifts of 1
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h81);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("so_l_%0d", i), so_l, exp_q.pop_front());
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    end
    check("lsb_sr",  sr_l,  8'hF0);
    check("lsb_cnt", cnt_l, 4'd3);
    check("lsb_st",  st_l,  SHIFTING);

    // update and enable priority
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("upd_5a",     up_m,  8'h5A);
    check("upd_5a_sr",  sr_m,  8'h5A);
    check("upd_5a_st",  st_m,  LOADED);
`ifdef FLEX_DR_SR_PARITY_EN
    check("upd_5a_par", par_m, 1'b0);
`endif
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h11);
    check("prio_sr",  sr_m,  8'h11);
    check("prio_cnt", cnt_m, 4'd0);
    check("prio_up",  up_m,  8'h5A);
    check("prio_st",  st_m,  LOADED);
    // shift beats update
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check("prio2_sr", sr_m, 8'h22);
    check("prio2_up", up_m, 8'h5A);

    // idle cycle holds everything
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    check("hold_sr",  sr_m,  8'h22);
    check("hold_cnt", cnt_m, 4'd1);

`ifdef FLEX_DR_SR_PARITY_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("upd_07",     up_m,  8'h07);
    check("upd_07_par", par_m, 1'b1);
`endif

    // reset mid-shift
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    shift_en = 1'b1;
    update_en = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_vals("midrst");
`ifdef FLEX_DR_SR_PARITY_EN
    check("midrst_par", par_m, 1'b0);
`endif
    shift_en = 1'b0;
    update_en = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    check("post_rst_st", st_m, EMPTY);
    check("post_rst_up", up_m, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
